// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
`timescale 1ns/1ps
package seg_pkg;
   localparam int BCD_W            = 4;
   localparam int SCAN_DIV_DEFAULT = 50000;
   // Wide enough for the largest supported display; callers slice to their digit count.
   localparam logic [7:0] AN_OFF   = 8'hFF;
endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one clk every SCAN_DIV cycles.
`timescale 1ns/1ps
module scan_prescaler
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end
endmodule

// File: rtl/bcd_digit_scanner.sv
// Scans a double-buffered packed-BCD value across a common-anode display, one digit per SCAN_DIV clks.
// NUM/AN are registered from the post-update index and shadow, so they change on the edge that moves idx.
`timescale 1ns/1ps
module bcd_digit_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = SCAN_DIV_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
   input  logic                        load,
   input  logic                        blank_lz,
   output logic                        busy,
   output logic [BCD_W-1:0]            NUM,
   output logic [NUM_DIGITS-1:0]       AN
);
   localparam int DW = BCD_W * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] DARK = AN_OFF[NUM_DIGITS-1:0];

   logic                  tick;
   logic                  boundary;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_next;
   logic [DW-1:0]         shadow;
   logic [DW-1:0]         shadow_next;
   logic [DW-1:0]         pending;
   logic [DW-1:0]         pending_next;
   logic                  busy_next;
   logic [BCD_W-1:0]      num_next;
   logic [NUM_DIGITS-1:0] an_next;
   logic                  zero_above;

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign boundary = tick && (idx == IDX_LAST);

   always_comb begin
      idx_next = idx;
      if (tick) begin
         idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
   end

   // A load on the boundary bypasses pending so it reaches the very next frame.
   always_comb begin
      shadow_next  = shadow;
      pending_next = pending;
      busy_next    = busy;
      if (boundary) begin
         busy_next = 1'b0;
         if (load) begin
            shadow_next = bcd_in;
         end else if (busy) begin
            shadow_next = pending;
         end
      end else if (load) begin
         pending_next = bcd_in;
         busy_next    = 1'b1;
      end
   end

   // Walk from the top digit down so zero_above covers digits NUM_DIGITS-1..i.
   always_comb begin
      num_next   = '0;
      an_next    = DARK;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (shadow_next[i*BCD_W +: BCD_W] == '0);
         if (idx_next == IW'(i)) begin
            num_next = shadow_next[i*BCD_W +: BCD_W];
            if (!(blank_lz && zero_above && (i != 0))) begin
               an_next    = DARK;
               an_next[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         shadow  <= '0;
         pending <= '0;
         busy    <= 1'b0;
         NUM     <= '0;
         AN      <= DARK;
      end else begin
         idx     <= idx_next;
         shadow  <= shadow_next;
         pending <= pending_next;
         busy    <= busy_next;
         NUM     <= num_next;
         AN      <= an_next;
      end
   end
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Scoreboard bench: stimulus queues per-slot AN/NUM expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_bcd_digit_scanner;
   typedef struct packed {
      logic [3:0] an;
      logic [3:0] num;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] bcd_in = '0;
   logic        busy;
   logic [3:0]  NUM;
   logic [3:0]  AN;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   // Posedges since reset release; each digit slot spans cycles 4s..4s+3 (slot 0 is 1..3).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   bcd_digit_scanner #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bcd_in   (bcd_in),
      .load     (load),
      .blank_lz (blank_lz),
      .busy     (busy),
      .NUM      (NUM),
      .AN       (AN)
   );

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && cyc >= 1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at cycle %0d: got AN=%b NUM=%0h with nothing expected", cyc, AN, NUM);
         end else begin
            chk($sformatf("AN cycle %0d", cyc), int'(AN), int'(sb_q[0].an));
            chk($sformatf("NUM cycle %0d", cyc), int'(NUM), int'(sb_q[0].num));
            if (cyc % 4 == 3) void'(sb_q.pop_front());
         end
      end
   end

   task automatic push_frame(input logic [15:0] ans, input logic [15:0] nums);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.an  = ans[4*i +: 4];
         e.num = nums[4*i +: 4];
         sb_q.push_back(e);
      end
   endtask

   // Returns at the negedge following posedge number c.
   task automatic wait_cyc(input int c);
      int n = 0;
      while (cyc != c && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != c) begin
         checks++;
         errors++;
         $display("FAIL wait_cyc: got cycle %0d expected %0d", cyc, c);
      end
   endtask

   task automatic load_at(input int c, input logic [15:0] v);
      wait_cyc(c - 1);
      bcd_in = v;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   localparam logic [15:0] WALK = 16'h7BDE;

   initial begin
      #12;
      chk("reset AN", int'(AN), 'hF);
      chk("reset NUM", int'(NUM), 0);
      chk("reset busy", int'(busy), 0);

      // 1: idle walk of zeros, frames 0 and 1
      push_frame(WALK, 16'h0000);
      push_frame(WALK, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(20);
      chk("idle busy", int'(busy), 0);

      // 2: mid-frame load of 1234 shows from frame 3
      push_frame(WALK, 16'h0000);
      push_frame(WALK, 16'h1234);
      load_at(38, 16'h1234);
      chk("busy after load", int'(busy), 1);
      wait_cyc(47);
      chk("busy before boundary", int'(busy), 1);
      wait_cyc(48);
      chk("busy after commit", int'(busy), 0);

      // 3: last of two loads wins
      push_frame(WALK, 16'h5678);
      load_at(52, 16'h1111);
      chk("busy first load", int'(busy), 1);
      load_at(56, 16'h5678);
      chk("busy second load", int'(busy), 1);
      wait_cyc(64);
      chk("busy after double commit", int'(busy), 0);

      // 4: load on the exact boundary goes straight to the display
      push_frame(WALK, 16'h9999);
      wait_cyc(79);
      chk("busy pre boundary load", int'(busy), 0);
      load_at(80, 16'h9999);
      chk("busy boundary load", int'(busy), 0);

      // 5: leading-zero blanking of 0040, then 0000
      push_frame(16'hFFDE, 16'h0040);
      push_frame(16'hFFFE, 16'h0000);
      load_at(90, 16'h0040);
      blank_lz = 1'b1;
      load_at(100, 16'h0000);
      chk("busy blank load", int'(busy), 1);
      wait_cyc(112);
      chk("busy blank commit", int'(busy), 0);

      // 6: reset mid-frame with a pending value
      load_at(116, 16'h1234);
      chk("busy before reset", int'(busy), 1);
      wait_cyc(118);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid reset AN", int'(AN), 'hF);
      chk("mid reset NUM", int'(NUM), 0);
      chk("mid reset busy", int'(busy), 0);
      sb_q.delete();
      blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      chk("held reset AN", int'(AN), 'hF);
      push_frame(WALK, 16'h0000);
      rst_n = 1'b1;
      wait_cyc(15);
      #1;
      chk("post reset busy", int'(busy), 0);
      chk("scoreboard drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
